bicubic_tap_apply: RTL and testbench

//   Consumer of the bicubic kernel-weight generators. Takes one column of four

---
 rtl/bicubic_pkg.sv | 26 ++
 rtl/bicubic_pipe_ctrl.sv | 33 +++
 rtl/bicubic_tap_apply.sv | 149 ++++++++++++++
 tb/tb_bicubic_tap_apply.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/bicubic_pkg.sv
// Shared constants and the output clamp used by the bicubic tap-apply datapath.
package bicubic_pkg;

    localparam int DW_DEFAULT = 8;
    localparam int WW_DEFAULT = 10;
    localparam int WF_DEFAULT = 8;
    localparam int UW_DEFAULT = 2;
    localparam int SUM_W      = DW_DEFAULT + WW_DEFAULT + 3;

    localparam logic signed [SUM_W-1:0] ROUND_CONST = SUM_W'(2 ** (WF_DEFAULT - 1));
    localparam logic signed [SUM_W-1:0] PIX_MAX     = SUM_W'(2 ** DW_DEFAULT - 1);

    // Clamp a shifted (already rounded) signed sum into the unsigned pixel range.
    function automatic logic [DW_DEFAULT-1:0] clamp_pix(input logic signed [SUM_W-1:0] v);
        logic [DW_DEFAULT-1:0] res;
        if (v[SUM_W-1]) begin
            res = {DW_DEFAULT{1'b0}};
        end else if (v > PIX_MAX) begin
            res = {DW_DEFAULT{1'b1}};
        end else begin
            res = v[DW_DEFAULT-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/bicubic_pipe_ctrl.sv
// Per-stage valid shift register and the global advance/ready term of a stall-all pipeline.
module bicubic_pipe_ctrl
    import bicubic_pkg::*;
#(
    parameter int STAGES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              out_ready,
    output logic              in_ready,
    output logic              adv,
    output logic [STAGES-1:0] stage_vld
);

    logic [STAGES-1:0] vld_r;

    assign adv       = ~vld_r[STAGES-1] | out_ready;
    assign in_ready  = adv;
    assign stage_vld = vld_r;

    // Stage valids shift together on advance and all hold on stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_r <= {STAGES{1'b0}};
        end else if (adv) begin
            vld_r <= {vld_r[STAGES-2:0], in_valid};
        end else begin
            vld_r <= vld_r;
        end
    end

endmodule

// File: rtl/bicubic_tap_apply.sv
// Four-tap weighted sum with half-up rounding and pixel clamp, 4-stage valid/ready pipeline.
module bicubic_tap_apply
    import bicubic_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int WW = WW_DEFAULT,
    parameter int WF = WF_DEFAULT,
    parameter int UW = UW_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DW-1:0]        p0,
    input  logic [DW-1:0]        p1,
    input  logic [DW-1:0]        p2,
    input  logic [DW-1:0]        p3,
    input  logic signed [WW-1:0] w0,
    input  logic signed [WW-1:0] w1,
    input  logic signed [WW-1:0] w2,
    input  logic signed [WW-1:0] w3,
    input  logic [UW-1:0]        in_user,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DW-1:0]        out_pix,
    output logic [UW-1:0]        out_user,
    input  logic                 cnt_clr,
    output logic [15:0]          sat_hi_cnt,
    output logic [15:0]          sat_lo_cnt
);

    localparam int PW = DW + WW + 1;
    localparam int SW = DW + WW + 3;

    logic                 adv_s;
    logic [3:0]           vld_s;
    logic [DW-1:0]        p_in_s  [4];
    logic signed [WW-1:0] w_in_s  [4];
    logic [DW-1:0]        p_s1_r  [4];
    logic signed [WW-1:0] w_s1_r  [4];
    logic signed [PW-1:0] prod_s2_r [4];
    logic signed [PW:0]   s01_s3_r;
    logic signed [PW:0]   s23_s3_r;
    logic [UW-1:0]        user_s1_r;
    logic [UW-1:0]        user_s2_r;
    logic [UW-1:0]        user_s3_r;
    logic signed [SW-1:0] sum_s;
    logic signed [SW-1:0] shifted_s;
    logic                 pre_hi_s;
    logic                 pre_lo_s;
    logic                 hi_inc_s;
    logic                 lo_inc_s;

    assign p_in_s = '{p0, p1, p2, p3};
    assign w_in_s = '{w0, w1, w2, w3};

    bicubic_pipe_ctrl #(.STAGES(4)) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .adv       (adv_s),
        .stage_vld (vld_s)
    );

    assign out_valid = vld_s[3];

    // S1 input capture, S2 products, S3 pair sums; a stage only loads behind a valid beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                p_s1_r[i]    <= {DW{1'b0}};
                w_s1_r[i]    <= {WW{1'b0}};
                prod_s2_r[i] <= {PW{1'b0}};
            end
            s01_s3_r  <= {(PW+1){1'b0}};
            s23_s3_r  <= {(PW+1){1'b0}};
            user_s1_r <= {UW{1'b0}};
            user_s2_r <= {UW{1'b0}};
            user_s3_r <= {UW{1'b0}};
        end else begin
            if (adv_s && in_valid) begin
                p_s1_r    <= p_in_s;
                w_s1_r    <= w_in_s;
                user_s1_r <= in_user;
            end
            if (adv_s && vld_s[0]) begin
                for (int i = 0; i < 4; i++) begin
                    prod_s2_r[i] <= $signed({1'b0, p_s1_r[i]}) * w_s1_r[i];
                end
                user_s2_r <= user_s1_r;
            end
            if (adv_s && vld_s[1]) begin
                s01_s3_r  <= (PW+1)'(prod_s2_r[0]) + (PW+1)'(prod_s2_r[1]);
                s23_s3_r  <= (PW+1)'(prod_s2_r[2]) + (PW+1)'(prod_s2_r[3]);
                user_s3_r <= user_s2_r;
            end
        end
    end

    // S4 combinational: final sum, half-up round, arithmetic shift and clamp classification.
    always_comb begin
        sum_s     = SW'(s01_s3_r) + SW'(s23_s3_r);
        shifted_s = (sum_s + ROUND_CONST) >>> WF;
        pre_lo_s  = shifted_s[SW-1];
        if (!shifted_s[SW-1] && (shifted_s > PIX_MAX)) begin
            pre_hi_s = 1'b1;
        end else begin
            pre_hi_s = 1'b0;
        end
        hi_inc_s = vld_s[2] & adv_s & pre_hi_s;
        lo_inc_s = vld_s[2] & adv_s & pre_lo_s;
    end

    // S4 output register; held while stalled so out_pix/out_user stay stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_pix  <= {DW{1'b0}};
            out_user <= {UW{1'b0}};
        end else if (adv_s && vld_s[2]) begin
            out_pix  <= clamp_pix(shifted_s);
            out_user <= user_s3_r;
        end else begin
            out_pix  <= out_pix;
            out_user <= out_user;
        end
    end

    // Saturating clamp counters; a clear beats a simultaneous increment.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            sat_hi_cnt <= 16'd0;
            sat_lo_cnt <= 16'd0;
        end else begin
            if (hi_inc_s && (sat_hi_cnt != 16'hFFFF)) begin
                sat_hi_cnt <= sat_hi_cnt + 16'd1;
            end else begin
                sat_hi_cnt <= sat_hi_cnt;
            end
            if (lo_inc_s && (sat_lo_cnt != 16'hFFFF)) begin
                sat_lo_cnt <= sat_lo_cnt + 16'd1;
            end else begin
                sat_lo_cnt <= sat_lo_cnt;
            end
        end
    end

endmodule

// File: tb/tb_bicubic_tap_apply.sv
// Self-checking bench: directed vector table, randomized stalled burst vs. a real-arithmetic model, reset/clear corners.
module tb_bicubic_tap_apply;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        p0, p1, p2, p3;
    logic signed [9:0] w0, w1, w2, w3;
    logic [1:0]        in_user;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_pix;
    logic [1:0]        out_user;
    logic              cnt_clr;
    logic [15:0]       sat_hi_cnt;
    logic [15:0]       sat_lo_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bicubic_tap_apply dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .p0(p0), .p1(p1), .p2(p2), .p3(p3),
        .w0(w0), .w1(w1), .w2(w2), .w3(w3),
        .in_user(in_user), .out_valid(out_valid), .out_ready(out_ready),
        .out_pix(out_pix), .out_user(out_user), .cnt_clr(cnt_clr),
        .sat_hi_cnt(sat_hi_cnt), .sat_lo_cnt(sat_lo_cnt)
    );

    typedef struct {
        int         p[4];
        int         w[4];
        logic [1:0] user;
        int         exp_pix;
        int         d_hi;
        int         d_lo;
    } vec_t;

    typedef struct {
        int         pix;
        logic [1:0] user;
    } exp_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: exact weighted sum in real arithmetic, floor((s + 0.5*256)/256), then clamp.
    function automatic void model(input int p[4], input int w[4],
                                  output int pix, output bit hi, output bit lo);
        real s = 0.0;
        int  v;
        for (int k = 0; k < 4; k++) s += real'(p[k]) * real'(w[k]);
        v  = int'($floor((s + 128.0) / 256.0));
        hi = (v > 255);
        lo = (v < 0);
        pix = hi ? 255 : (lo ? 0 : v);
    endfunction

    task automatic drive(input int p[4], input int w[4], input logic [1:0] u);
        p0 = 8'(p[0]); p1 = 8'(p[1]); p2 = 8'(p[2]); p3 = 8'(p[3]);
        w0 = 10'(w[0]); w1 = 10'(w[1]); w2 = 10'(w[2]); w3 = 10'(w[3]);
        in_user = u;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[9];
        exp_t q[$];
        int   exp_hi, exp_lo, edges, sent, cycles, m_pix;
        bit   m_hi, m_lo, hold_pend;
        int   hold_pix, hold_user;
        int   rp[4], rw[4];
        exp_t e;

        vecs[0] = '{'{10, 20, 30, 40},    '{0, 256, 0, 0},       2'b01, 20,  0, 0};
        vecs[1] = '{'{0, 255, 255, 0},    '{-32, 288, 288, -32}, 2'b10, 255, 1, 0};
        vecs[2] = '{'{255, 0, 0, 255},    '{-32, 160, 160, -32}, 2'b11, 0,   0, 1};
        vecs[3] = '{'{1, 0, 0, 0},        '{128, 0, 0, 0},       2'b00, 1,   0, 0};
        vecs[4] = '{'{1, 0, 0, 0},        '{127, 0, 0, 0},       2'b01, 0,   0, 0};
        vecs[5] = '{'{1, 0, 0, 0},        '{-128, 0, 0, 0},      2'b10, 0,   0, 0};
        vecs[6] = '{'{1, 0, 0, 0},        '{-129, 0, 0, 0},      2'b11, 0,   0, 1};
        vecs[7] = '{'{255, 255, 255, 255}, '{64, 64, 64, 64},    2'b01, 255, 0, 0};
        vecs[8] = '{'{255, 0, 0, 0},      '{257, 0, 0, 0},       2'b10, 255, 1, 0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
        drive('{0, 0, 0, 0}, '{0, 0, 0, 0}, 2'b00);
        step(); step();
        rst = 1'b0;
        @(negedge clk);
        check("reset out_valid", int'(out_valid), 0);
        check("reset in_ready", int'(in_ready), 1);
        check("reset out_pix", int'(out_pix), 0);
        check("reset out_user", int'(out_user), 0);
        check("reset sat_hi", int'(sat_hi_cnt), 0);
        check("reset sat_lo", int'(sat_lo_cnt), 0);
        step();

        // Directed table: one isolated beat each, latency, value, sideband, counters.
        exp_hi = 0; exp_lo = 0;
        foreach (vecs[i]) begin
            drive(vecs[i].p, vecs[i].w, vecs[i].user);
            in_valid = 1'b1;
            @(negedge clk);
            check($sformatf("vec%0d in_ready", i), int'(in_ready), 1);
            step();
            in_valid = 1'b0;
            edges = 1;
            while (edges < 10) begin
                @(negedge clk);
                if (out_valid) break;
                step();
                edges++;
            end
            exp_hi += vecs[i].d_hi;
            exp_lo += vecs[i].d_lo;
            check($sformatf("vec%0d latency", i), edges, 4);
            check($sformatf("vec%0d out_pix", i), int'(out_pix), vecs[i].exp_pix);
            check($sformatf("vec%0d out_user", i), int'(out_user), int'(vecs[i].user));
            check($sformatf("vec%0d sat_hi", i), int'(sat_hi_cnt), exp_hi);
            check($sformatf("vec%0d sat_lo", i), int'(sat_lo_cnt), exp_lo);
            step();
        end

        // Random burst of 20 beats with random gaps and random out_ready stalls.
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        exp_hi = 0; exp_lo = 0; sent = 0; cycles = 0; hold_pend = 1'b0;
        hold_pix = 0; hold_user = 0;
        while (((sent < 20) || (q.size() != 0)) && (cycles < 500)) begin
            in_valid  = (sent < 20) && ($urandom_range(3) != 0);
            out_ready = ($urandom_range(1) == 1);
            for (int k = 0; k < 4; k++) begin
                rp[k] = int'($urandom_range(255));
                rw[k] = (k == 0 || k == 3) ? -int'($urandom_range(80)) : int'($urandom_range(300));
            end
            drive(rp, rw, 2'($urandom_range(3)));
            @(negedge clk);
            if (hold_pend) begin
                check("burst hold valid", int'(out_valid), 1);
                check("burst hold pix", int'(out_pix), hold_pix);
                check("burst hold user", int'(out_user), hold_user);
            end
            hold_pend = out_valid && !out_ready;
            hold_pix  = int'(out_pix);
            hold_user = int'(out_user);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("burst unexpected beat", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("burst out_pix", int'(out_pix), e.pix);
                    check("burst out_user", int'(out_user), int'(e.user));
                end
            end
            if (in_valid && in_ready) begin
                model(rp, rw, m_pix, m_hi, m_lo);
                q.push_back('{m_pix, in_user});
                exp_hi += int'(m_hi);
                exp_lo += int'(m_lo);
                sent++;
            end
            step();
            cycles++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("burst beats sent", sent, 20);
        check("burst queue drained", q.size(), 0);
        @(negedge clk);
        check("burst sat_hi", int'(sat_hi_cnt), exp_hi);
        check("burst sat_lo", int'(sat_lo_cnt), exp_lo);
        step();

        // Reset with three beats in flight: nothing may emerge afterwards.
        for (int b = 0; b < 3; b++) begin
            drive(vecs[b].p, vecs[b].w, vecs[b].user);
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("flush out_valid", int'(out_valid), 0);
        edges = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid) edges++;
            step();
        end
        check("flush stale beats", edges, 0);

        // cnt_clr coinciding with a clamp-high increment leaves the counter at zero.
        drive(vecs[1].p, vecs[1].w, vecs[1].user);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        @(negedge clk);
        check("clr out_valid", int'(out_valid), 1);
        check("clr out_pix", int'(out_pix), 255);
        check("clr sat_hi", int'(sat_hi_cnt), 0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
